// File: rtl/invert_filter.sv
// Multi-channel input conditioner: 2-flop synchroniser, per-channel debounce
// counter, selectable inversion and registered one-cycle edge pulses.
module invert_filter #(
  parameter int                 WIDTH         = 4,
  parameter int                 STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0]   INVERT_MASK   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] input1,
  output logic [WIDTH-1:0] output1,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed
);

  localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] out_old, out_new;

  // A differing level must be seen on STABLE_CYCLES consecutive enabled edges;
  // any return to the accepted level wipes the count.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (enable) begin
        if (s2_q[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          state_d[i] = s2_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edges are judged on the visible (post-mask) level; with enable low the
  // state cannot move, so the pulses drop to zero by construction.
  always_comb begin
    out_old   = state_q ^ INVERT_MASK;
    out_new   = state_d ^ INVERT_MASK;
    rise_d    = out_new & ~out_old;
    fall_d    = ~out_new & out_old;
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      state_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= input1;
      s2_q      <= s1_q;
      state_q   <= state_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign output1    = state_q ^ INVERT_MASK;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign changed    = changed_q;

endmodule

// File: tb/tb_invert_filter.sv
// Bench for invert_filter: default-mask instance plus a 4'b0101-mask instance,
// expected output events queued at stimulus time and retired on their due edge.
module tb_invert_filter;

  logic       clk     = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst, enable;
  logic [3:0] input1;
  logic [3:0] output1, rise_pulse, fall_pulse;
  logic       changed;
  logic       rst2, en2;
  logic [3:0] in2;
  logic [3:0] out2, rise2, fall2;
  logic       chg2;

  always #5 if (clk_run) clk = ~clk;

  invert_filter #(.WIDTH(4), .STABLE_CYCLES(4), .INVERT_MASK(4'hF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .input1(input1),
    .output1(output1), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .changed(changed)
  );

  invert_filter #(.WIDTH(4), .STABLE_CYCLES(4), .INVERT_MASK(4'b0101)) dut_m (
    .clk(clk), .rst(rst2), .enable(en2), .input1(in2),
    .output1(out2), .rise_pulse(rise2), .fall_pulse(fall2),
    .changed(chg2)
  );

  typedef struct {
    int         due;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  exp_t       q1[$];
  exp_t       q2[$];
  logic [3:0] x1_out, x1_r, x1_f;
  logic       x1_c;
  logic [3:0] x2_out, x2_r, x2_f;
  logic       x2_c;
  int         edge_n    = 0;
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  // Advance one edge, then retire any expectation due on that edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    edge_n++;
    #1;
    x1_r = 4'h0; x1_f = 4'h0;
    x2_r = 4'h0; x2_f = 4'h0;
    if (q1.size() > 0 && q1[0].due == edge_n) begin
      e = q1.pop_front();
      x1_out = e.out; x1_r = e.rise; x1_f = e.fall;
    end
    if (q2.size() > 0 && q2[0].due == edge_n) begin
      e = q2.pop_front();
      x2_out = e.out; x2_r = e.rise; x2_f = e.fall;
    end
    x1_c = |(x1_r | x1_f);
    x2_c = |(x2_r | x2_f);
  endtask

  // Input driven now is first sampled on the next edge E0; result due at E0+5.
  task automatic push1(input int lat, input logic [3:0] o, input logic [3:0] r, input logic [3:0] f);
    q1.push_back('{due: edge_n + lat, out: o, rise: r, fall: f});
  endtask

  task automatic push2(input int lat, input logic [3:0] o, input logic [3:0] r, input logic [3:0] f);
    q2.push_back('{due: edge_n + lat, out: o, rise: r, fall: f});
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1; enable = 1'b1; en2 = 1'b1;
    input1 = 4'h0; in2 = 4'h0;
    #5;
    total_cnt++;
    if ({output1, rise_pulse, fall_pulse, changed} !== {4'hF, 4'h0, 4'h0, 1'b0})
      $display("FAIL reset_noclk: out=%h rise=%b fall=%b chg=%b, want out=f rise=0000 fall=0000 chg=0",
               output1, rise_pulse, fall_pulse, changed);
    else pass_cnt++;
    total_cnt++;
    if ({out2, rise2, fall2, chg2} !== {4'h5, 4'h0, 4'h0, 1'b0})
      $display("FAIL reset_mask_noclk: out=%h rise=%b fall=%b chg=%b, want out=5 rise=0000 fall=0000 chg=0",
               out2, rise2, fall2, chg2);
    else pass_cnt++;
    x1_out = 4'hF; x2_out = 4'h5;
    clk_run = 1'b1;
    tick(); tick();
    rst = 1'b0; rst2 = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      total_cnt++;
      if ({output1, rise_pulse, fall_pulse, changed} !== {x1_out, x1_r, x1_f, x1_c})
        $display("FAIL reset_idle edge %0d: out=%h rise=%b fall=%b chg=%b, want out=%h rise=%b fall=%b chg=%b",
                 edge_n, output1, rise_pulse, fall_pulse, changed, x1_out, x1_r, x1_f, x1_c);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_fall();
    input1 = 4'h1;
    push1(6, 4'hE, 4'h0, 4'h1);
    for (int n = 0; n < 12; n++) begin
      tick();
      total_cnt++;
      if ({output1, rise_pulse, fall_pulse, changed} !== {x1_out, x1_r, x1_f, x1_c})
        $display("FAIL single_fall edge %0d: out=%h rise=%b fall=%b chg=%b, want out=%h rise=%b fall=%b chg=%b",
                 edge_n, output1, rise_pulse, fall_pulse, changed, x1_out, x1_r, x1_f, x1_c);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    input1 = 4'h3;
    for (int n = 0; n < 11; n++) begin
      if (n == 3) input1 = 4'h1;
      tick();
      total_cnt++;
      if ({output1, rise_pulse, fall_pulse, changed} !== {x1_out, x1_r, x1_f, x1_c})
        $display("FAIL glitch3 edge %0d: out=%h rise=%b fall=%b chg=%b, want out=%h rise=%b fall=%b chg=%b",
                 edge_n, output1, rise_pulse, fall_pulse, changed, x1_out, x1_r, x1_f, x1_c);
      else pass_cnt++;
    end
    input1 = 4'h3;
    push1(6, 4'hC, 4'h0, 4'h2);
    for (int n = 0; n < 14; n++) begin
      if (n == 4) begin
        input1 = 4'h1;
        push1(6, 4'hE, 4'h2, 4'h0);
      end
      tick();
      total_cnt++;
      if ({output1, rise_pulse, fall_pulse, changed} !== {x1_out, x1_r, x1_f, x1_c})
        $display("FAIL glitch4 edge %0d: out=%h rise=%b fall=%b chg=%b, want out=%h rise=%b fall=%b chg=%b",
                 edge_n, output1, rise_pulse, fall_pulse, changed, x1_out, x1_r, x1_f, x1_c);
      else pass_cnt++;
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    input1 = 4'h8;
    for (int n = 0; n < 18; n++) begin
      if (n == 10) begin
        enable = 1'b1;
        push1(4, 4'h7, 4'h1, 4'h8);
      end
      tick();
      total_cnt++;
      if ({output1, rise_pulse, fall_pulse, changed} !== {x1_out, x1_r, x1_f, x1_c})
        $display("FAIL enable_freeze edge %0d: out=%h rise=%b fall=%b chg=%b, want out=%h rise=%b fall=%b chg=%b",
                 edge_n, output1, rise_pulse, fall_pulse, changed, x1_out, x1_r, x1_f, x1_c);
      else pass_cnt++;
    end
    // Two edges counted, pause, then two more complete the qualification.
    input1 = 4'h0;
    for (int n = 0; n < 15; n++) begin
      if (n == 4) enable = 1'b0;
      if (n == 9) begin
        enable = 1'b1;
        push1(2, 4'hF, 4'h8, 4'h0);
      end
      tick();
      total_cnt++;
      if ({output1, rise_pulse, fall_pulse, changed} !== {x1_out, x1_r, x1_f, x1_c})
        $display("FAIL enable_resume edge %0d: out=%h rise=%b fall=%b chg=%b, want out=%h rise=%b fall=%b chg=%b",
                 edge_n, output1, rise_pulse, fall_pulse, changed, x1_out, x1_r, x1_f, x1_c);
      else pass_cnt++;
    end
  endtask

  task automatic test_mask();
    in2 = 4'hF;
    push2(6, 4'hA, 4'b1010, 4'b0101);
    for (int n = 0; n < 10; n++) begin
      tick();
      total_cnt++;
      if ({out2, rise2, fall2, chg2} !== {x2_out, x2_r, x2_f, x2_c})
        $display("FAIL mask0101 edge %0d: out=%h rise=%b fall=%b chg=%b, want out=%h rise=%b fall=%b chg=%b",
                 edge_n, out2, rise2, fall2, chg2, x2_out, x2_r, x2_f, x2_c);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    input1 = 4'h2;
    push1(6, 4'hD, 4'h0, 4'h2);
    for (int n = 0; n < 12; n++) begin
      if (n == 8) input1 = 4'h1;
      tick();
      total_cnt++;
      if ({output1, rise_pulse, fall_pulse, changed} !== {x1_out, x1_r, x1_f, x1_c})
        $display("FAIL reset_mid_pre edge %0d: out=%h rise=%b fall=%b chg=%b, want out=%h rise=%b fall=%b chg=%b",
                 edge_n, output1, rise_pulse, fall_pulse, changed, x1_out, x1_r, x1_f, x1_c);
      else pass_cnt++;
    end
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({output1, rise_pulse, fall_pulse, changed} !== {4'hF, 4'h0, 4'h0, 1'b0})
      $display("FAIL reset_mid_async: out=%h rise=%b fall=%b chg=%b, want out=f rise=0000 fall=0000 chg=0",
               output1, rise_pulse, fall_pulse, changed);
    else pass_cnt++;
    q1.delete();
    x1_out = 4'hF;
    tick(); tick();
    rst = 1'b0;
    push1(6, 4'hE, 4'h0, 4'h1);
    for (int n = 0; n < 10; n++) begin
      tick();
      total_cnt++;
      if ({output1, rise_pulse, fall_pulse, changed} !== {x1_out, x1_r, x1_f, x1_c})
        $display("FAIL reset_mid_post edge %0d: out=%h rise=%b fall=%b chg=%b, want out=%h rise=%b fall=%b chg=%b",
                 edge_n, output1, rise_pulse, fall_pulse, changed, x1_out, x1_r, x1_f, x1_c);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_fall();
    test_glitch();
    test_enable();
    test_mask();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
